seq_monitor: RTL and testbench

SEQ_MONITOR -- requirements
Module: seq_monitor

---
 rtl/seq_monitor.sv | 138 +++++++++++++
 tb/tb_seq_monitor.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_monitor.sv
// Sequence monitor for the 7-state SR counter: hunts, syncs and locks onto the code sequence, flags errors and wraps.
// Optional wrap counter is compiled in with SEQ_MONITOR_WRAP_CNT_EN; all outputs are registered one clock after the sample.
module seq_monitor (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] code,
  input  logic       code_valid,
  output logic [2:0] pos,
  output logic       locked,
  output logic       err,
  output logic       wrap,
  output logic [3:0] err_cnt,
  output logic [7:0] wrap_cnt
);

  localparam logic [1:0] HUNT   = 2'd0;
  localparam logic [1:0] SYNC   = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;
  localparam logic [1:0] ERR    = 2'd3;

  logic [1:0] state, nxt_state;
  logic [2:0] prev, nxt_prev;
  logic [1:0] match, nxt_match;
  logic [2:0] idx;
  logic       legal;
  logic [2:0] succ;
  logic       is_succ;
  logic       do_err;
  logic       do_wrap;

  always_comb begin
    legal = 1'b1;
    idx   = 3'd7;
    case (code)
      3'b000:  idx = 3'd0;
      3'b111:  idx = 3'd1;
      3'b110:  idx = 3'd2;
      3'b101:  idx = 3'd3;
      3'b001:  idx = 3'd4;
      3'b010:  idx = 3'd5;
      3'b011:  idx = 3'd6;
      default: legal = 1'b0;
    endcase
  end

  // A repeated index is never a successor, so it naturally breaks sync/lock.
  assign succ    = (prev == 3'd6) ? 3'd0 : prev + 3'd1;
  assign is_succ = legal && (idx == succ);

  always_comb begin
    nxt_state = state;
    nxt_prev  = prev;
    nxt_match = match;
    do_err    = 1'b0;
    do_wrap   = 1'b0;
    case (state)
      HUNT: begin
        if (legal) begin
          nxt_state = SYNC;
          nxt_prev  = idx;
          nxt_match = 2'd0;
        end
      end
      SYNC: begin
        if (!legal) begin
          nxt_state = HUNT;
        end else begin
          nxt_prev = idx;
          if (is_succ) begin
            nxt_match = match + 2'd1;
            if (match == 2'd2) nxt_state = LOCKED;
          end else begin
            nxt_match = 2'd0;
          end
        end
      end
      LOCKED: begin
        if (legal) nxt_prev = idx;
        if (is_succ) begin
          do_wrap = (prev == 3'd6);
        end else begin
          nxt_state = ERR;
          do_err    = 1'b1;
        end
      end
      default: begin
        if (legal) begin
          nxt_state = SYNC;
          nxt_prev  = idx;
          nxt_match = 2'd0;
        end else begin
          nxt_state = HUNT;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= HUNT;
      prev    <= 3'd0;
      match   <= 2'd0;
      pos     <= 3'd0;
      locked  <= 1'b0;
      err     <= 1'b0;
      wrap    <= 1'b0;
      err_cnt <= 4'd0;
    end else if (code_valid) begin
      state   <= nxt_state;
      prev    <= nxt_prev;
      match   <= nxt_match;
      pos     <= idx;
      locked  <= (nxt_state == LOCKED);
      err     <= (nxt_state == ERR);
      wrap    <= do_wrap;
      if (do_err && (err_cnt != 4'd15)) err_cnt <= err_cnt + 4'd1;
    end else begin
      wrap <= 1'b0;
    end
  end

`ifdef SEQ_MONITOR_WRAP_CNT_EN
  logic [7:0] wrap_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrap_cnt_q <= 8'd0;
    end else if (code_valid && do_wrap && (wrap_cnt_q != 8'd255)) begin
      wrap_cnt_q <= wrap_cnt_q + 8'd1;
    end
  end

  assign wrap_cnt = wrap_cnt_q;
`else
  assign wrap_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_seq_monitor.sv
// Scoreboard bench for seq_monitor: stimulus pushes expected outputs, a monitor pops and compares after each clock.
module tb_seq_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] code = 3'd0;
  logic       code_valid = 1'b0;
  logic [2:0] pos;
  logic       locked, err, wrap;
  logic [3:0] err_cnt;
  logic [7:0] wrap_cnt;

  typedef struct packed {
    logic [2:0] pos;
    logic       locked;
    logic       err;
    logic       wrap;
    logic [3:0] err_cnt;
    logic [7:0] wrap_cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // reference model state: 0 HUNT, 1 SYNC, 2 LOCKED, 3 ERR
  int m_st, m_prev, m_match, m_pos, m_wrap, m_errc, m_wrapc;

  seq_monitor dut (
    .clk(clk), .reset(reset), .code(code), .code_valid(code_valid),
    .pos(pos), .locked(locked), .err(err), .wrap(wrap),
    .err_cnt(err_cnt), .wrap_cnt(wrap_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  function automatic logic [2:0] code_of(input int i);
    case (i)
      0: code_of = 3'b000;
      1: code_of = 3'b111;
      2: code_of = 3'b110;
      3: code_of = 3'b101;
      4: code_of = 3'b001;
      5: code_of = 3'b010;
      default: code_of = 3'b011;
    endcase
  endfunction

  task automatic model_reset();
    m_st = 0; m_prev = 0; m_match = 0; m_pos = 0; m_wrap = 0; m_errc = 0; m_wrapc = 0;
  endtask

  task automatic model_step(input logic [2:0] c, input logic v);
    int ix, sc;
    bit lg;
    m_wrap = 0;
    if (v) begin
      ix = 7;
      for (int i = 0; i < 7; i++) if (code_of(i) == c) ix = i;
      lg = (ix != 7);
      m_pos = ix;
      sc = (m_prev + 1) % 7;
      case (m_st)
        0: if (lg) begin m_st = 1; m_prev = ix; m_match = 0; end
        1: begin
          if (!lg) m_st = 0;
          else begin
            if (ix == sc) begin
              m_match++;
              if (m_match == 3) m_st = 2;
            end else m_match = 0;
            m_prev = ix;
          end
        end
        2: begin
          if (lg && ix == sc) begin
            if (m_prev == 6) begin
              m_wrap = 1;
              if (m_wrapc < 255) m_wrapc++;
            end
          end else begin
            m_st = 3;
            if (m_errc < 15) m_errc++;
          end
          if (lg) m_prev = ix;
        end
        default: begin
          if (lg) begin m_st = 1; m_match = 0; m_prev = ix; end
          else m_st = 0;
        end
      endcase
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.pos     = 3'(m_pos);
    e.locked  = (m_st == 2);
    e.err     = (m_st == 3);
    e.wrap    = m_wrap[0];
`ifdef SEQ_MONITOR_WRAP_CNT_EN
    e.wrap_cnt = 8'(m_wrapc);
`else
    e.wrap_cnt = 8'd0;
`endif
    e.err_cnt = 4'(m_errc);
    return e;
  endfunction

  // One sample per negedge; its expected response is queued for the monitor.
  task automatic drive(input logic [2:0] c, input logic v);
    @(negedge clk);
    code = c;
    code_valid = v;
    model_step(c, v);
    exp_q.push_back(model_out());
  endtask

  task automatic drive_idx(input int i);
    drive(code_of(i), 1'b1);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  initial begin : monitor
    exp_t e, a;
    forever begin
      @(posedge clk);
      if (exp_q.size() > 0) begin
        #1;
        e = exp_q.pop_front();
        a = '{pos, locked, err, wrap, err_cnt, wrap_cnt};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL scoreboard t=%0t: got pos=%0d lk=%0d er=%0d wr=%0d ec=%0d wc=%0d expected pos=%0d lk=%0d er=%0d wr=%0d ec=%0d wc=%0d",
                   $time, a.pos, a.locked, a.err, a.wrap, a.err_cnt, a.wrap_cnt,
                   e.pos, e.locked, e.err, e.wrap, e.err_cnt, e.wrap_cnt);
        end
      end
    end
  end

  initial begin : stim
    int exp_wc;
    model_reset();
    #12;
    chk("reset_pos", pos, 0);
    chk("reset_locked", locked, 0);
    chk("reset_err", err, 0);
    chk("reset_wrap", wrap, 0);
    chk("reset_err_cnt", err_cnt, 0);
    chk("reset_wrap_cnt", wrap_cnt, 0);
    @(negedge clk);
    reset = 1'b0;

    // acquire lock: 000,111,110,101
    drive(3'b000, 1'b1); drive(3'b111, 1'b1); drive(3'b110, 1'b1); drive(3'b101, 1'b1);
    settle();
    chk("lock_locked", locked, 1);
    chk("lock_pos", pos, 3);

    // 001,010,011,000 -> wrap
    drive(3'b001, 1'b1); drive(3'b010, 1'b1); drive(3'b011, 1'b1); drive(3'b000, 1'b1);
    settle();
    chk("wrap_pulse", wrap, 1);
    chk("wrap_locked", locked, 1);
`ifdef SEQ_MONITOR_WRAP_CNT_EN
    chk("wrap_cnt_one", wrap_cnt, 1);
`else
    chk("wrap_cnt_off", wrap_cnt, 0);
`endif
    drive(3'b111, 1'b1);
    settle();
    chk("wrap_one_cycle", wrap, 0);

    // locked at index 2, inject 001 -> ERR
    drive(3'b110, 1'b1);
    drive(3'b001, 1'b1);
    settle();
    chk("err_err", err, 1);
    chk("err_locked", locked, 0);
    chk("err_cnt_one", err_cnt, 1);
    drive(3'b010, 1'b1);
    settle();
    chk("err_exit_err", err, 0);
    chk("err_exit_locked", locked, 0);

    // in SYNC, illegal code -> HUNT
    drive(3'b100, 1'b1);
    settle();
    chk("illegal_pos", pos, 7);
    chk("illegal_locked", locked, 0);

    // relock, then hold with code_valid low
    for (int i = 0; i < 4; i++) drive_idx(i);
    for (int i = 0; i < 5; i++) begin
      drive(3'($urandom_range(0, 7)), 1'b0);
      settle();
      chk("hold_wrap", wrap, 0);
      chk("hold_pos", pos, 3);
      chk("hold_locked", locked, 1);
    end

    // 300 full wraps
    for (int i = 4; i < 7; i++) drive_idx(i);
    for (int w = 0; w < 300; w++)
      for (int i = 0; i < 7; i++) drive_idx(i);
    settle();
`ifdef SEQ_MONITOR_WRAP_CNT_EN
    exp_wc = 255;
`else
    exp_wc = 0;
`endif
    chk("wrap_cnt_sat", wrap_cnt, exp_wc);

    // 20 forced errors by repeating the last code
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < 4; i++) drive_idx(i);
      drive_idx(3);
    end
    settle();
    chk("err_cnt_sat", err_cnt, 15);
    chk("err_cnt_sat_err", err, 1);

    // relock, then asynchronous reset between clock edges
    for (int i = 0; i < 4; i++) drive_idx(i);
    settle();
    chk("prereset_locked", locked, 1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("areset_pos", pos, 0);
    chk("areset_locked", locked, 0);
    chk("areset_err", err, 0);
    chk("areset_wrap", wrap, 0);
    chk("areset_err_cnt", err_cnt, 0);
    chk("areset_wrap_cnt", wrap_cnt, 0);
    @(negedge clk);
    reset = 1'b0;

    // fresh sync needed after release
    drive(3'b101, 1'b1);
    settle();
    chk("post_reset_unlocked", locked, 0);
    chk("post_reset_no_err", err, 0);
    drive_idx(4); drive_idx(5); drive_idx(6);
    settle();
    chk("post_reset_relock", locked, 1);

    @(negedge clk);
    code_valid = 1'b0;
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
